// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style control FSM: states, opcodes,
// datapath mux codes and the control word that the decoder produces.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

   localparam ctrl_t CTRL_ZERO = 17'd0;

   function automatic logic is_supported_op(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
         default:                                       ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Clears every write/strobe field while leaving the mux selects intact.
   function automatic ctrl_t clear_strobes(input ctrl_t c);
      ctrl_t g;
      g               = c;
      g.pc_write      = 1'b0;
      g.pc_write_cond = 1'b0;
      g.mem_read      = 1'b0;
      g.mem_write     = 1'b0;
      g.ir_write      = 1'b0;
      g.reg_write     = 1'b0;
      g.instr_done    = 1'b0;
      return g;
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore decode of the current FSM state into the datapath control word.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   // State-to-control-word table; unlisted fields stay at zero.
   always_comb begin
      ctrl = CTRL_ZERO;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write  = 1'b1;
            ctrl.i_or_d     = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.instr_done    = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         S_ADDI_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: ctrl = CTRL_ZERO;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: state register, opcode-driven next-state logic and
// reset gating of the decoded control strobes.
module multicycle_control
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t state_r;
   state_t next_state_s;
   ctrl_t  ctrl_s;
   ctrl_t  ctrl_out_s;
   logic   illegal_s;

   // State register; reset returns to FETCH without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; opcode is only consulted in DECODE and MEM_ADDR.
   always_comb begin
      next_state_s = S_FETCH;
      case (state_r)
         S_FETCH: next_state_s = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     next_state_s = S_EXECUTE;
               OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
               OP_BEQ:       next_state_s = S_BRANCH;
               OP_J:         next_state_s = S_JUMP;
               OP_ADDI:      next_state_s = S_ADDI_EXEC;
               default:      next_state_s = S_FETCH;
            endcase
         end
         S_MEM_ADDR: begin
            case (opcode)
               OP_LW:   next_state_s = S_MEM_READ;
               OP_SW:   next_state_s = S_MEM_WRITE;
               default: next_state_s = S_FETCH;
            endcase
         end
         S_MEM_READ:  next_state_s = S_MEM_WB;
         S_EXECUTE:   next_state_s = S_R_WB;
         S_ADDI_EXEC: next_state_s = S_ADDI_WB;
         S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                      next_state_s = S_FETCH;
         default:     next_state_s = S_FETCH;
      endcase
   end

   mc_ctrl_decode u_decode (
      .state (state_r),
      .ctrl  (ctrl_s)
   );

   // Strobes are held low for as long as reset is asserted.
   always_comb begin
      illegal_s = (state_r == S_DECODE) && !is_supported_op(opcode);
      if (rst) begin
         ctrl_out_s = clear_strobes(ctrl_s);
         illegal_s  = 1'b0;
      end else begin
         ctrl_out_s = ctrl_s;
      end
   end

   assign pc_write      = ctrl_out_s.pc_write;
   assign pc_write_cond = ctrl_out_s.pc_write_cond;
   assign i_or_d        = ctrl_out_s.i_or_d;
   assign mem_read      = ctrl_out_s.mem_read;
   assign mem_write     = ctrl_out_s.mem_write;
   assign ir_write      = ctrl_out_s.ir_write;
   assign mem_to_reg    = ctrl_out_s.mem_to_reg;
   assign reg_dst       = ctrl_out_s.reg_dst;
   assign reg_write     = ctrl_out_s.reg_write;
   assign alu_src_a     = ctrl_out_s.alu_src_a;
   assign alu_src_b     = ctrl_out_s.alu_src_b;
   assign alu_op        = ctrl_out_s.alu_op;
   assign pc_source     = ctrl_out_s.pc_source;
   assign instr_done    = ctrl_out_s.instr_done;
   assign illegal_op    = illegal_s;
   assign state         = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Scenario bench for multicycle_control: per-cycle expected state/opcode pairs
// are queued by each scenario and popped against the DUT on the falling edge.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   typedef struct {
      logic [5:0] op;
      logic [3:0] st;
   } sb_entry_t;

   sb_entry_t   sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          done_cnt, wr_cnt, ill_cnt, rw_cnt;
   logic [17:0] obs;

   multicycle_control dut (
      .clk (clk), .rst (rst), .opcode (opcode),
      .pc_write (pc_write), .pc_write_cond (pc_write_cond), .i_or_d (i_or_d),
      .mem_read (mem_read), .mem_write (mem_write), .ir_write (ir_write),
      .mem_to_reg (mem_to_reg), .reg_dst (reg_dst), .reg_write (reg_write),
      .alu_src_a (alu_src_a), .alu_src_b (alu_src_b), .alu_op (alu_op),
      .pc_source (pc_source), .instr_done (instr_done), .illegal_op (illegal_op),
      .state (state)
   );

   always #5 clk = ~clk;

   assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, instr_done, illegal_op};

   // Reference control word straight from the state table.
   function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                            input logic r);
      logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn, il;
      logic [1:0] sbm, ao, ps;
      {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn, il} = 12'd0;
      sbm = 2'b00; ao = 2'b00; ps = 2'b00;
      case (st)
         4'd0:        begin mr = 1'b1; irw = 1'b1; pw = 1'b1; sbm = 2'b01; end
         4'd1:        begin sbm = 2'b11;
                            il = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                              6'b000100, 6'b000010, 6'b001000}); end
         4'd2, 4'd10: begin sa = 1'b1; sbm = 2'b10; end
         4'd3:        begin mr = 1'b1; iod = 1'b1; end
         4'd4:        begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
         4'd5:        begin mw = 1'b1; iod = 1'b1; dn = 1'b1; end
         4'd6:        begin sa = 1'b1; ao = 2'b10; end
         4'd7:        begin rw = 1'b1; rd = 1'b1; dn = 1'b1; end
         4'd8:        begin sa = 1'b1; ao = 2'b01; pwc = 1'b1; ps = 2'b01; dn = 1'b1; end
         4'd9:        begin pw = 1'b1; ps = 2'b10; dn = 1'b1; end
         4'd11:       begin rw = 1'b1; dn = 1'b1; end
         default:     ;
      endcase
      if (r) {pw, pwc, mr, mw, irw, rw, dn, il} = 8'd0;
      return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sbm, ao, ps, dn, il};
   endfunction

   task automatic push(input logic [5:0] op, input logic [3:0] st);
      sb_entry_t e;
      e.op = op;
      e.st = st;
      sb.push_back(e);
   endtask

   // Pops one entry per cycle, drives its opcode and compares state and outputs.
   task automatic drain(input string tag);
      sb_entry_t   e;
      logic [17:0] exp;
      done_cnt = 0; wr_cnt = 0; ill_cnt = 0; rw_cnt = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         opcode = e.op;
         #1;
         n_checks++;
         if (state !== e.st)
            $display("FAIL %s state: got %0d expected %0d", tag, state, e.st);
         else n_pass++;
         exp = exp_ctrl(e.st, e.op, 1'b0);
         n_checks++;
         if (obs !== exp)
            $display("FAIL %s ctrl in state %0d: got %b expected %b", tag, e.st, obs, exp);
         else n_pass++;
         if (instr_done) done_cnt++;
         if (reg_write || mem_write) wr_cnt++;
         if (reg_write) rw_cnt++;
         if (illegal_op) ill_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (state !== 4'd0) $display("FAIL reset state: got %0d expected 0", state);
      else n_pass++;
      n_checks++;
      if (obs !== exp_ctrl(4'd0, opcode, 1'b1))
         $display("FAIL reset ctrl: got %b expected %b", obs, exp_ctrl(4'd0, opcode, 1'b1));
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lw();
      push(6'b100011, 4'd0); push(6'b100011, 4'd1); push(6'b100011, 4'd2);
      push(6'b100011, 4'd3); push(6'b100011, 4'd4);
      drain("lw");
      n_checks++;
      if (done_cnt !== 1) $display("FAIL lw done pulses: got %0d expected 1", done_cnt);
      else n_pass++;
   endtask

   task automatic test_sw();
      push(6'b101011, 4'd0); push(6'b101011, 4'd1); push(6'b101011, 4'd2);
      push(6'b101011, 4'd5);
      drain("sw");
      n_checks++;
      if (rw_cnt !== 0 || wr_cnt !== 1)
         $display("FAIL sw writes: got reg %0d any %0d expected reg 0 any 1", rw_cnt, wr_cnt);
      else n_pass++;
   endtask

   task automatic test_beq();
      push(6'b000100, 4'd0); push(6'b000100, 4'd1); push(6'b000100, 4'd8);
      drain("beq");
   endtask

   task automatic test_back_to_back();
      push(6'b000000, 4'd0); push(6'b000000, 4'd1); push(6'b000000, 4'd6);
      push(6'b000000, 4'd7);
      push(6'b000010, 4'd0); push(6'b000010, 4'd1); push(6'b000010, 4'd9);
      drain("rtype_j");
      n_checks++;
      if (done_cnt !== 2) $display("FAIL rtype_j done pulses: got %0d expected 2", done_cnt);
      else n_pass++;
   endtask

   task automatic test_illegal();
      push(6'b111111, 4'd0); push(6'b111111, 4'd1);
      drain("illegal");
      n_checks++;
      if (ill_cnt !== 1 || wr_cnt !== 0)
         $display("FAIL illegal pulses/writes: got %0d/%0d expected 1/0", ill_cnt, wr_cnt);
      else n_pass++;
   endtask

   task automatic test_addi();
      push(6'b001000, 4'd0); push(6'b001000, 4'd1); push(6'b001000, 4'd10);
      push(6'b001000, 4'd11);
      drain("addi");
   endtask

   task automatic test_mid_reset();
      push(6'b100011, 4'd0); push(6'b100011, 4'd1); push(6'b100011, 4'd2);
      drain("midrst_pre");
      #1;
      n_checks++;
      if (state !== 4'd3) $display("FAIL midrst before: got %0d expected 3", state);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (state !== 4'd0) $display("FAIL midrst async state: got %0d expected 0", state);
      else n_pass++;
      n_checks++;
      if (obs !== exp_ctrl(4'd0, opcode, 1'b1))
         $display("FAIL midrst strobes: got %b expected %b", obs, exp_ctrl(4'd0, opcode, 1'b1));
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (state !== 4'd0 || obs !== exp_ctrl(4'd0, opcode, 1'b1))
         $display("FAIL midrst held: got state %0d ctrl %b expected 0 %b", state, obs,
                  exp_ctrl(4'd0, opcode, 1'b1));
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      push(6'b100011, 4'd0); push(6'b100011, 4'd1);
      drain("midrst_post");
   endtask

   initial begin
      rst    = 1'b1;
      opcode = 6'b000000;
      repeat (2) @(negedge clk);
      test_reset();
      test_lw();
      test_sw();
      test_beq();
      test_back_to_back();
      test_illegal();
      test_addi();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed constants.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- opcode  in  6  instruction bits [31:26] from the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write-data select: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final state of every instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- state  out  4  current state encoding, for debug.

Function
REQ-003 The FSM SHALL have 12 states with these encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
REQ-004 The FSM SHALL follow these transitions:
- FETCH -> DECODE.
- DECODE on opcode: 000000 -> EXECUTE; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EXEC; any other value -> FETCH.
- MEM_ADDR -> MEM_READ for lw, or MEM_WRITE for sw.
- MEM_READ -> MEM_WB.
- EXECUTE -> R_WB.
- ADDI_EXEC -> ADDI_WB.
- MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP and ADDI_WB -> FETCH.
REQ-005 Outputs SHALL be Moore, decoded from state only; any output not listed for a state SHALL be 0:
- FETCH: mem_read, ir_write, pc_write = 1; alu_src_b = 01; alu_op = 00; pc_source = 00.
- DECODE: alu_src_b = 11; alu_op = 00.
- MEM_ADDR and ADDI_EXEC: alu_src_a = 1; alu_src_b = 10; alu_op = 00.
- MEM_READ: mem_read, i_or_d = 1.
- MEM_WB: reg_write, mem_to_reg = 1.
- MEM_WRITE: mem_write, i_or_d = 1.
- EXECUTE: alu_src_a = 1; alu_src_b = 00; alu_op = 10.
- R_WB: reg_write, reg_dst = 1.
- BRANCH: alu_src_a = 1; alu_op = 01; pc_write_cond = 1; pc_source = 01.
- JUMP: pc_write = 1; pc_source = 10.
- ADDI_WB: reg_write = 1.
REQ-006 Instruction latency in cycles, FETCH through the final state inclusive, SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-007 instr_done SHALL be 1 exactly in MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP and ADDI_WB.
REQ-008 An illegal opcode SHALL cost 2 cycles, pulse illegal_op in DECODE and produce no register or memory write.
REQ-009 opcode SHALL be sampled only in DECODE and MEM_ADDR; it is stable because ir_write is 0 outside FETCH.
REQ-010 mem_read and mem_write SHALL never both be 1, and pc_write and pc_write_cond SHALL never both be 1.

Reset
REQ-011 rst high SHALL force state to FETCH asynchronously.
REQ-012 While rst is high, all write and strobe outputs (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op) SHALL be 0; select outputs SHALL show FETCH values.
REQ-013 Deassertion of rst SHALL begin FETCH at the next rising clk edge; reset mid-instruction SHALL abandon the instruction with no further writes.

Structure
REQ-014 State encodings, opcode constants, and alu_op/alu_src_b/pc_source codes SHALL live in a shared package mc_ctrl_pkg.
REQ-015 The state register and next-state logic SHALL be in multicycle_control; state-to-control-word decoding SHALL be one sub-module, mc_ctrl_decode.

Verification
REQ-016 The bench SHALL cover at least these directed scenarios:
- Reset, release, opcode=100011 -> states 0,1,2,3,4,0; reg_write and mem_to_reg = 1 only in state 4; instr_done pulses once.
- opcode=101011 -> states 0,1,2,5,0; mem_write=1 and i_or_d=1 in state 5 only; reg_write never 1.
- opcode=000100 -> states 0,1,8,0; in state 8 pc_write_cond=1, alu_op=01, pc_source=01; DECODE shows alu_src_b=11.
- opcode=000000 then 000010 back-to-back -> states 0,1,6,7,0,1,9,0; pc_write=1 with pc_source=10 in state 9.
- opcode=111111 -> states 0,1,0; illegal_op pulses in state 1; no writes.
- rst asserted mid-cycle in state 3 -> state=0 immediately without a clock edge; all strobes 0 while rst is high.
